// File: rtl/card_deck.sv
// card_deck: 52-card deck server for the blackjack controller.
// Shuffles a register-array deck with Fisher-Yates, using a free-running
// 16-bit Galois LFSR as the random source, and deals one card per request.
//
// Ports:
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   start_shuffle     shuffle request (acts on rising edge)
//   start_card        deal request (acts on rising edge)
//   shuffling         high while the shuffle is in progress
//   shuffle_ready     deck shuffled and dealable
//   card_ready        one-cycle pulse when card_* carry a new card
//   card_rank/suit    1..13 / 0..3 of the last dealt card
//   card_value        blackjack value of the last dealt card
//   cards_left        undealt cards, 0..52
//   deck_empty        no cards left while shuffle_ready
module card_deck #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_shuffle,
  input  logic       start_card,
  output logic       shuffling,
  output logic       shuffle_ready,
  output logic       card_ready,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       deck_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PICK,
    S_SWAP,
    S_READY
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic        start_shuffle_q, start_card_q;
  logic [5:0]  deck_q [52];
  logic [5:0]  i_q, i_d;
  logic [5:0]  j_q, j_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  left_q, left_d;
  logic        card_ready_q, card_ready_d;
  logic [3:0]  rank_q, rank_d;
  logic [1:0]  suit_q, suit_d;
  logic [3:0]  value_q, value_d;

  logic        req_shuffle, req_card;
  logic [5:0]  pick_r;
  logic [5:0]  code, base;
  logic [1:0]  code_suit;
  logic [3:0]  code_rank;

  assign req_shuffle = start_shuffle & ~start_shuffle_q;
  assign req_card    = start_card & ~start_card_q;

  // Smallest 2^n-1 covering v, so a masked LFSR draw rejects less than half the time.
  function automatic logic [5:0] pick_mask(input logic [5:0] v);
    if (v[5])      return 6'h3F;
    else if (v[4]) return 6'h1F;
    else if (v[3]) return 6'h0F;
    else if (v[2]) return 6'h07;
    else if (v[1]) return 6'h03;
    else           return 6'h01;
  endfunction

  assign pick_r = lfsr_q[5:0] & pick_mask(i_q);

  // Decode the card at the deal pointer: suit = code/13, rank = code mod 13 + 1.
  always_comb begin
    code = deck_q[ptr_q];
    if (code >= 6'd39) begin
      code_suit = 2'd3;
      base      = 6'd39;
    end else if (code >= 6'd26) begin
      code_suit = 2'd2;
      base      = 6'd26;
    end else if (code >= 6'd13) begin
      code_suit = 2'd1;
      base      = 6'd13;
    end else begin
      code_suit = 2'd0;
      base      = 6'd0;
    end
    code_rank = 4'(code - base + 6'd1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      lfsr_q          <= LFSR_SEED;
      start_shuffle_q <= 1'b0;
      start_card_q    <= 1'b0;
      i_q             <= '0;
      j_q             <= '0;
      ptr_q           <= '0;
      left_q          <= '0;
      card_ready_q    <= 1'b0;
      rank_q          <= '0;
      suit_q          <= '0;
      value_q         <= '0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400)
                                   : {1'b0, lfsr_q[15:1]};
      start_shuffle_q <= start_shuffle;
      start_card_q    <= start_card;
      i_q             <= i_d;
      j_q             <= j_d;
      ptr_q           <= ptr_d;
      left_q          <= left_d;
      card_ready_q    <= card_ready_d;
      rank_q          <= rank_d;
      suit_q          <= suit_d;
      value_q         <= value_d;
    end
  end

  // Deck contents are meaningless until INIT rewrites them, so no reset here.
  always_ff @(posedge clock) begin
    if (state_q == S_INIT) begin
      for (int unsigned k = 0; k < 52; k++) deck_q[k] <= 6'(k);
    end else if (state_q == S_SWAP) begin
      deck_q[i_q] <= deck_q[j_q];
      deck_q[j_q] <= deck_q[i_q];
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    ptr_d        = ptr_q;
    left_d       = left_q;
    card_ready_d = 1'b0;
    rank_d       = rank_q;
    suit_d       = suit_q;
    value_d      = value_q;
    case (state_q)
      S_IDLE: begin
        if (req_shuffle) state_d = S_INIT;
      end
      S_INIT: begin
        i_d     = 6'd51;
        ptr_d   = '0;
        state_d = S_PICK;
      end
      S_PICK: begin
        if (pick_r <= i_q) begin
          j_d     = pick_r;
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        if (i_q == 6'd1) begin
          left_d  = 6'd52;
          state_d = S_READY;
        end else begin
          i_d     = i_q - 6'd1;
          state_d = S_PICK;
        end
      end
      S_READY: begin
        if (req_shuffle) begin
          state_d = S_INIT;
        end else if (req_card && (left_q != '0)) begin
          card_ready_d = 1'b1;
          rank_d       = code_rank;
          suit_d       = code_suit;
          value_d      = (code_rank > 4'd10) ? 4'd10 : code_rank;
          ptr_d        = ptr_q + 6'd1;
          left_d       = left_q - 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign shuffling     = (state_q == S_INIT) || (state_q == S_PICK) || (state_q == S_SWAP);
  assign shuffle_ready = (state_q == S_READY);
  assign deck_empty    = shuffle_ready && (left_q == '0);
  assign card_ready    = card_ready_q;
  assign card_rank     = rank_q;
  assign card_suit     = suit_q;
  assign card_value    = value_q;
  assign cards_left    = left_q;

endmodule

// File: tb/tb_card_deck.sv
// Testbench for card_deck: randomized deal timing, a Fisher-Yates reference
// model fed by a model of the shuffle LFSR, and a scoreboard/monitor pair.
module tb_card_deck;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_shuffle = 1'b0;
  logic       start_card = 1'b0;
  logic       shuffling, shuffle_ready, card_ready, deck_empty;
  logic [3:0] card_rank, card_value;
  logic [1:0] card_suit;
  logic [5:0] cards_left;

  always #5 clock = ~clock;

  card_deck #(.LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset),
    .start_shuffle(start_shuffle), .start_card(start_card),
    .shuffling(shuffling), .shuffle_ready(shuffle_ready),
    .card_ready(card_ready), .card_rank(card_rank), .card_suit(card_suit),
    .card_value(card_value), .cards_left(cards_left), .deck_empty(deck_empty)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Cycle index and the LFSR value valid during that cycle.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  logic [15:0] lfsr_m;
  always @(posedge clock or posedge reset)
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= lfsr_step(lfsr_m);

  typedef struct {
    int cyc;
    int rank;
    int suit;
    int value;
    int left;
  } exp_t;
  exp_t expq[$];

  int mdeck[52];
  int mptr, mleft, exp_ready, exp_i30;
  int last_rank = 0, last_suit = 0, last_value = 0;
  bit seen[52];
  int dut_codes[$];

  // Reference shuffle: classic Fisher-Yates with rejection sampling. l is the
  // random word available in cycle c (first draw cycle); one draw per cycle,
  // one cycle per swap. Leaves the ready cycle in exp_ready.
  task automatic model_shuffle(input logic [15:0] l_start, input int c_start);
    logic [15:0] l;
    int c, m, r, t;
    l = l_start;
    c = c_start;
    for (int k = 0; k < 52; k++) mdeck[k] = k;
    for (int i = 51; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      if (i == 30) exp_i30 = c;
      do begin
        r = int'(l[5:0]) & m;
        l = lfsr_step(l);
        c++;
      end while (r > i);
      t = mdeck[i]; mdeck[i] = mdeck[r]; mdeck[r] = t;
      l = lfsr_step(l);
      c++;
    end
    exp_ready = c;
    mptr = 0;
    mleft = 52;
  endtask

  // Monitor: every card_ready pulse must match the oldest expected deal.
  always @(negedge clock) begin : monitor
    exp_t e;
    int code;
    if (!reset && card_ready) begin
      code = int'(card_suit) * 13 + int'(card_rank) - 1;
      if (expq.size() == 0) begin
        check("unexpected_card_ready", 1, 0);
      end else begin
        e = expq.pop_front();
        check("deal_cycle", cyc, e.cyc);
        check("card_rank", card_rank, e.rank);
        check("card_suit", card_suit, e.suit);
        check("card_value", card_value, e.value);
        check("cards_left_after_deal", cards_left, e.left);
      end
      if (code >= 0 && code < 52) seen[code] = 1'b1;
      dut_codes.push_back(code);
    end
  end

  task automatic do_shuffle(input bit poke);
    int n;
    @(negedge clock);
    start_shuffle = 1'b1;
    model_shuffle(lfsr_step(lfsr_step(lfsr_m)), cyc + 2);
    @(negedge clock);
    start_shuffle = 1'b0;
    check("shuffling_after_req", shuffling, 1);
    check("ready_low_while_shuffling", shuffle_ready, 0);
    if (poke) begin
      // Both requests must be ignored while the shuffle runs.
      repeat (3) @(negedge clock);
      start_card = 1'b1;
      start_shuffle = 1'b1;
      @(negedge clock);
      start_card = 1'b0;
      start_shuffle = 1'b0;
    end
    n = 0;
    while (!shuffle_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (!shuffle_ready) begin
      check("shuffle_timeout", 0, 1);
    end else begin
      check("ready_cycle", cyc, exp_ready);
      check("shuffling_at_ready", shuffling, 0);
      check("cards_left_at_ready", cards_left, 52);
      check("deck_empty_at_ready", deck_empty, 0);
    end
  endtask

  task automatic deal(input int hold);
    exp_t e;
    int c;
    @(negedge clock);
    start_card = 1'b1;
    if (mleft > 0) begin
      c = mdeck[mptr];
      e.cyc = cyc + 1;
      e.rank = c % 13 + 1;
      e.suit = c / 13;
      e.value = (e.rank > 10) ? 10 : e.rank;
      mptr++;
      mleft--;
      e.left = mleft;
      expq.push_back(e);
      last_rank = e.rank;
      last_suit = e.suit;
      last_value = e.value;
    end
    repeat (hold) @(negedge clock);
    start_card = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic drain();
    repeat (3) @(negedge clock);
    check("scoreboard_drained", expq.size(), 0);
  endtask

  function automatic int count_seen();
    int s = 0;
    for (int k = 0; k < 52; k++) s += int'(seen[k]);
    return s;
  endfunction

  int first_a[5];
  int same;
  int n;

  initial begin
    // Reset state
    repeat (5) @(negedge clock);
    check("rst_shuffling", shuffling, 0);
    check("rst_shuffle_ready", shuffle_ready, 0);
    check("rst_card_ready", card_ready, 0);
    check("rst_card_rank", card_rank, 0);
    check("rst_card_suit", card_suit, 0);
    check("rst_card_value", card_value, 0);
    check("rst_cards_left", cards_left, 0);
    check("rst_deck_empty", deck_empty, 0);
    reset = 1'b0;
    repeat ($urandom_range(0, 7)) @(negedge clock);

    // Shuffle with ignored requests mid-way, then deal the whole deck
    do_shuffle(1'b1);
    for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    for (int k = 0; k < 52; k++) deal(1);
    drain();
    check("permutation_52", count_seen(), 52);
    check("deck_empty_after_52", deck_empty, 1);
    check("cards_left_after_52", cards_left, 0);

    // 53rd request is ignored and card outputs hold
    deal(1);
    repeat (2) @(negedge clock);
    check("hold_rank_53", card_rank, last_rank);
    check("hold_suit_53", card_suit, last_suit);
    check("hold_value_53", card_value, last_value);
    check("deck_empty_53", deck_empty, 1);

    // Reshuffle keeps the last card; held start_card deals only once
    do_shuffle(1'b0);
    check("rank_kept_over_shuffle", card_rank, last_rank);
    dut_codes.delete();
    deal(10);
    for (int k = 0; k < 4; k++) deal(1);
    drain();
    check("cards_left_47", cards_left, 47);
    for (int k = 0; k < 5; k++) first_a[k] = (dut_codes.size() > k) ? dut_codes[k] : -1;

    // Reshuffle after a partial deal gives a full deck in a new order
    do_shuffle(1'b0);
    dut_codes.delete();
    for (int k = 0; k < 5; k++) deal(1);
    drain();
    check("cards_left_47_b", cards_left, 47);
    same = 1;
    for (int k = 0; k < 5; k++)
      if (dut_codes.size() <= k || dut_codes[k] != first_a[k]) same = 0;
    check("new_order_after_reshuffle", same, 0);

    // Reset in the middle of a shuffle (at i=30)
    @(negedge clock);
    start_shuffle = 1'b1;
    model_shuffle(lfsr_step(lfsr_step(lfsr_m)), cyc + 2);
    @(negedge clock);
    start_shuffle = 1'b0;
    n = 0;
    while (cyc < exp_i30 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("reached_i30", int'(cyc >= exp_i30), 1);
    reset = 1'b1;
    #1;
    check("midrst_shuffling", shuffling, 0);
    check("midrst_ready", shuffle_ready, 0);
    check("midrst_cards_left", cards_left, 0);
    check("midrst_card_rank", card_rank, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_after_reset", shuffling, 0);

    // Deterministic shuffle from the seed, full deal against the model
    do_shuffle(1'b0);
    for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    for (int k = 0; k < 52; k++) deal(1);
    drain();
    check("permutation_52_post_reset", count_seen(), 52);
    check("deck_empty_post_reset", deck_empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
